actor_mover: RTL

ACTOR_MOVER -- requirements
Module: actor_mover

---
 rtl/actor_pkg.sv | 43 ++++
 rtl/key_decode.sv | 20 ++
 rtl/actor_mover.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/actor_pkg.sv
// Shared types for maze actors: directions, keycodes, movement states and helpers.
package actor_pkg;

   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_DOWN  = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_RIGHT = 3'd4
   } dir_t;

   typedef enum logic {
      StStop,
      StMove
   } state_t;

   localparam logic [7:0] KEY_UP    = 8'h0C;
   localparam logic [7:0] KEY_DOWN  = 8'h0E;
   localparam logic [7:0] KEY_LEFT  = 8'h0D;
   localparam logic [7:0] KEY_RIGHT = 8'h0F;

   function automatic dir_t opposite(input dir_t d);
      case (d)
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         default:   return DIR_NONE;
      endcase
   endfunction

   // Wall flags are ordered {right,left,down,up}.
   function automatic logic dir_blocked(input dir_t d, input logic [3:0] blocked);
      case (d)
         DIR_UP:    return blocked[0];
         DIR_DOWN:  return blocked[1];
         DIR_LEFT:  return blocked[2];
         DIR_RIGHT: return blocked[3];
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/key_decode.sv
// Combinational USB keycode to direction decoder; unknown codes map to DIR_NONE.
module key_decode
   import actor_pkg::*;
(
   input  logic [7:0] keycode,
   output dir_t       key_dir
);

   always_comb begin
      key_dir = DIR_NONE;
      case (keycode)
         KEY_UP:    key_dir = DIR_UP;
         KEY_DOWN:  key_dir = DIR_DOWN;
         KEY_LEFT:  key_dir = DIR_LEFT;
         KEY_RIGHT: key_dir = DIR_RIGHT;
         default:   key_dir = DIR_NONE;
      endcase
   end

endmodule

// File: rtl/actor_mover.sv
// Tile-aligned maze actor mover with buffered turn requests.
// Define TUNNEL_WRAP_EN to wrap X at the playfield edges instead of clamping.
module actor_mover
   import actor_pkg::*;
#(
   parameter int unsigned CW        = 10,
   parameter int unsigned STEP      = 1,
   parameter int unsigned TILE      = 16,
   parameter int unsigned X_MIN     = 0,
   parameter int unsigned X_MAX     = 639,
   parameter int unsigned Y_MIN     = 0,
   parameter int unsigned Y_MAX     = 479,
   parameter int unsigned START_X   = 328,
   parameter int unsigned START_Y   = 248,
   parameter dir_t        START_DIR = DIR_LEFT
) (
   input  logic          frame_clk,
   input  logic          Reset,
   input  logic          enable,
   input  logic [7:0]    keycode,
   input  logic [3:0]    blocked,
   output logic [CW-1:0] PosX,
   output logic [CW-1:0] PosY,
   output logic [CW-1:0] Size,
   output dir_t          dir,
   output logic          moving,
   output logic          turn_pending
);

   localparam logic [CW-1:0] StepC    = CW'(STEP);
   localparam logic [CW-1:0] TileMask = CW'(TILE - 1);
   localparam logic [CW-1:0] HalfTile = CW'(TILE / 2);
   localparam logic [CW-1:0] XMinC    = CW'(X_MIN);
   localparam logic [CW-1:0] XMaxC    = CW'(X_MAX);
   localparam logic [CW-1:0] YMinC    = CW'(Y_MIN);
   localparam logic [CW-1:0] YMaxC    = CW'(Y_MAX);
   // Positions beyond these thresholds would cross a limit on the next step.
   localparam logic [CW-1:0] XLoLim   = CW'(X_MIN + STEP);
   localparam logic [CW-1:0] XHiLim   = CW'(X_MAX - STEP);
   localparam logic [CW-1:0] YLoLim   = CW'(Y_MIN + STEP);
   localparam logic [CW-1:0] YHiLim   = CW'(Y_MAX - STEP);

   state_t        state_q, state_d;
   dir_t          dir_q, dir_d;
   dir_t          pend_q, pend_d;
   logic [CW-1:0] pos_x_q, pos_x_d;
   logic [CW-1:0] pos_y_q, pos_y_d;

   dir_t          key_dir;
   dir_t          req;
   dir_t          move_dir;
   logic [CW-1:0] off_x, off_y;
   logic          aligned;
   logic          take;

   key_decode u_key_decode (
      .keycode (keycode),
      .key_dir (key_dir)
   );

   assign off_x   = pos_x_q - XMinC;
   assign off_y   = pos_y_q - YMinC;
   assign aligned = ((off_x & TileMask) == HalfTile) && ((off_y & TileMask) == HalfTile);

   // A fresh keycode wins over the buffered request.
   assign req  = (key_dir != DIR_NONE) ? key_dir : pend_q;
   assign take = (req != DIR_NONE) &&
                 ((req == opposite(dir_q)) || (aligned && !dir_blocked(req, blocked)));

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      pend_d   = pend_q;
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      move_dir = DIR_NONE;

      if (take) begin
         dir_d    = req;
         pend_d   = DIR_NONE;
         state_d  = StMove;
         move_dir = req;
      end else begin
         if (key_dir != DIR_NONE) pend_d = key_dir;
         if (state_q == StMove) begin
            if (aligned && dir_blocked(dir_q, blocked)) state_d = StStop;
            else                                        move_dir = dir_q;
         end
      end

      case (move_dir)
         DIR_UP: begin
            if (pos_y_q < YLoLim) begin
               pos_y_d = YMinC;
               state_d = StStop;
            end else pos_y_d = pos_y_q - StepC;
         end
         DIR_DOWN: begin
            if (pos_y_q > YHiLim) begin
               pos_y_d = YMaxC;
               state_d = StStop;
            end else pos_y_d = pos_y_q + StepC;
         end
         DIR_LEFT: begin
            if (pos_x_q < XLoLim) begin
`ifdef TUNNEL_WRAP_EN
               pos_x_d = XMaxC;
`else
               pos_x_d = XMinC;
               state_d = StStop;
`endif
            end else pos_x_d = pos_x_q - StepC;
         end
         DIR_RIGHT: begin
            if (pos_x_q > XHiLim) begin
`ifdef TUNNEL_WRAP_EN
               pos_x_d = XMinC;
`else
               pos_x_d = XMaxC;
               state_d = StStop;
`endif
            end else pos_x_d = pos_x_q + StepC;
         end
         default: ;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q <= StMove;
         dir_q   <= START_DIR;
         pend_q  <= DIR_NONE;
         pos_x_q <= CW'(START_X);
         pos_y_q <= CW'(START_Y);
      end else if (enable) begin
         state_q <= state_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
      end
   end

   assign PosX         = pos_x_q;
   assign PosY         = pos_y_q;
   assign Size         = HalfTile;
   assign dir          = dir_q;
   assign moving       = (state_q == StMove);
   assign turn_pending = (pend_q != DIR_NONE);

endmodule
